// File: rtl/mem_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_resp_pkg
// Brief    : Shared types and constants for the physical memory responder.
// Revision : 1.0
// ============================================================================
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [31:0] C_ERR_DATA_DEFAULT = 32'hDEADBEEF;
  localparam int          C_CNT_W            = 32;

  function automatic logic [C_CNT_W-1:0] sat_inc(input logic [C_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_resp_ram.sv
`default_nettype none
// ============================================================================
// Module   : mem_resp_ram
// Brief    : Word storage, one write port and one registered read port.
// Revision : 1.0
// ============================================================================
module mem_resp_ram #(
  parameter int WORDS = 4096,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] r_mem [WORDS];
  logic [31:0] r_rdata;

  // No reset: contents must survive responder resets.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
    if (re) r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/phys_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : phys_mem_responder
// Brief    : Four-phase handshake memory responder with fixed latency.
// Revision : 1.0
// ============================================================================
module phys_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter int          LATENCY   = 4,
  parameter logic [31:0] ERR_DATA  = C_ERR_DATA_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               VMEM_Request,
  output logic               VMEM_ACK,
  input  logic [31:0]        VMEM_Address,
  input  logic               VMEM_WE,
  inout  wire  [31:0]        VMEM_dataBus,
  input  logic               load_en,
  input  logic [31:0]        load_addr,
  input  logic [31:0]        load_data,
  output logic [C_CNT_W-1:0] rd_cnt,
  output logic [C_CNT_W-1:0] wr_cnt,
  output logic [C_CNT_W-1:0] abort_cnt,
  output logic [C_CNT_W-1:0] err_cnt
);

  localparam int          AW           = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [29:0] C_WORD_LIMIT = 30'(MEM_WORDS);
  localparam logic [3:0]  C_LAT_LOAD   = 4'(LATENCY - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_lat_cnt, w_lat_cnt_nxt;
  logic [29:0] r_word;
  logic        r_we;
  logic [31:0] r_wdata;
  logic        r_rd_err;
  logic        w_enter_ack, w_abort;
  logic [29:0] w_txn_word;
  logic        w_txn_we, w_txn_in_range;
  logic [31:0] w_txn_wdata;
  logic        w_bd_ok, w_ram_we, w_ram_re;
  logic [AW-1:0] w_ram_waddr;
  logic [31:0] w_ram_wdata, w_ram_rdata, w_rd_data;
  logic        w_unused_bits;

  assign w_unused_bits = ^{VMEM_Address[1:0], load_addr[1:0]};

  // With LATENCY==1 the commit edge is the sampling edge, so use live inputs.
  assign w_txn_word     = (r_state == IDLE) ? VMEM_Address[31:2] : r_word;
  assign w_txn_we       = (r_state == IDLE) ? VMEM_WE : r_we;
  assign w_txn_wdata    = (r_state == IDLE) ? VMEM_dataBus : r_wdata;
  assign w_txn_in_range = (w_txn_word < C_WORD_LIMIT);

  always_comb begin
    w_state_nxt   = r_state;
    w_lat_cnt_nxt = r_lat_cnt;
    w_enter_ack   = 1'b0;
    w_abort       = 1'b0;
    case (r_state)
      IDLE: begin
        if (VMEM_Request) begin
          if (LATENCY == 1) begin
            w_state_nxt = ACK;
            w_enter_ack = 1'b1;
          end else begin
            w_state_nxt   = WAIT;
            w_lat_cnt_nxt = C_LAT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!VMEM_Request) begin
          w_state_nxt = IDLE;
          w_abort     = 1'b1;
        end else if (r_lat_cnt == 4'd0) begin
          w_state_nxt = ACK;
          w_enter_ack = 1'b1;
        end else begin
          w_lat_cnt_nxt = r_lat_cnt - 4'd1;
        end
      end
      ACK: begin
        if (!VMEM_Request) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_lat_cnt <= 4'd0;
      r_word    <= 30'd0;
      r_we      <= 1'b0;
      r_wdata   <= 32'd0;
      r_rd_err  <= 1'b0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      abort_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_cnt <= w_lat_cnt_nxt;
      if (r_state == IDLE && VMEM_Request) begin
        r_word <= VMEM_Address[31:2];
        r_we   <= VMEM_WE;
        if (VMEM_WE) r_wdata <= VMEM_dataBus;
      end
      if (w_enter_ack) begin
        r_rd_err <= !w_txn_we && !w_txn_in_range;
        if (w_txn_we) wr_cnt <= sat_inc(wr_cnt);
        else          rd_cnt <= sat_inc(rd_cnt);
        if (!w_txn_in_range) err_cnt <= sat_inc(err_cnt);
      end
      if (w_abort) abort_cnt <= sat_inc(abort_cnt);
    end
  end

  // Backdoor and transaction writes are mutually exclusive by state/request.
  assign w_bd_ok     = load_en && (r_state == IDLE) && !VMEM_Request &&
                       (load_addr[31:2] < C_WORD_LIMIT);
  assign w_ram_we    = rst_n && ((w_enter_ack && w_txn_we && w_txn_in_range) || w_bd_ok);
  assign w_ram_re    = rst_n && w_enter_ack && !w_txn_we && w_txn_in_range;
  assign w_ram_waddr = w_enter_ack ? w_txn_word[AW-1:0] : load_addr[AW+1:2];
  assign w_ram_wdata = w_enter_ack ? w_txn_wdata : load_data;

  mem_resp_ram #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .waddr (w_ram_waddr),
    .wdata (w_ram_wdata),
    .re    (w_ram_re),
    .raddr (w_txn_word[AW-1:0]),
    .rdata (w_ram_rdata)
  );

  assign w_rd_data    = r_rd_err ? ERR_DATA : w_ram_rdata;
  assign VMEM_ACK     = (r_state == ACK);
  assign VMEM_dataBus = (r_state == ACK && !r_we) ? w_rd_data : 32'bz;

endmodule
`default_nettype wire

// File: tb/tb_phys_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_phys_mem_responder
// Brief    : Directed self-checking bench for phys_mem_responder.
// Revision : 1.0
// ============================================================================
module tb_phys_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic        load_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;
  logic [31:0] drv_data = '0;
  logic        drv_en = 1'b0;
  logic        ack;
  logic [31:0] rd_cnt, wr_cnt, abort_cnt, err_cnt;
  tri1  [31:0] bus;

  int tests = 0;
  int fails = 0;

  // The pull-up makes an undriven bus read as all ones.
  assign bus = drv_en ? drv_data : 32'bz;

  always #5 clk = ~clk;

  phys_mem_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .VMEM_Request (req),
    .VMEM_ACK     (ack),
    .VMEM_Address (addr),
    .VMEM_WE      (we),
    .VMEM_dataBus (bus),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .rd_cnt       (rd_cnt),
    .wr_cnt       (wr_cnt),
    .abort_cnt    (abort_cnt),
    .err_cnt      (err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic backdoor(input logic [31:0] a, input logic [31:0] d);
    load_addr = a;
    load_data = d;
    load_en   = 1'b1;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Full handshake; inputs are disturbed after sampling to prove they are latched.
  task automatic txn(input logic [31:0] a, input logic w, input logic [31:0] d,
                     output logic [31:0] rd, output int lat);
    addr     = a;
    we       = w;
    drv_data = d;
    drv_en   = w;
    req      = 1'b1;
    tick();
    addr     = a ^ 32'h0000_0040;
    drv_data = ~d;
    lat      = 0;
    while (!ack && lat < 40) begin
      tick();
      lat++;
    end
    rd     = bus;
    req    = 1'b0;
    drv_en = 1'b0;
    tick();
    check("ack_drop", {31'd0, ack}, 32'd0);
  endtask

  logic [31:0] rdata;
  int          lat;
  bit          saw_ack;

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_bus", bus, 32'hFFFF_FFFF);
    check("rst_rd_cnt", rd_cnt, 32'd0);
    check("rst_wr_cnt", wr_cnt, 32'd0);
    check("rst_abort_cnt", abort_cnt, 32'd0);
    check("rst_err_cnt", err_cnt, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    saw_ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack) saw_ack = 1'b1;
    end
    check("no_spurious_ack", {31'd0, saw_ack}, 32'd0);

    // Backdoor load then read with latency measurement
    backdoor(32'h0000_1000, 32'h0000_2000);
    txn(32'h0000_1000, 1'b0, 32'h0, rdata, lat);
    check("rd_latency", 32'(lat), 32'd4);
    check("rd_data_1000", rdata, 32'h0000_2000);
    check("rd_cnt_1", rd_cnt, 32'd1);

    // Page-walk pair; memory must survive the reset
    pulse_reset();
    check("rd_cnt_after_rst", rd_cnt, 32'd0);
    backdoor(32'h0000_2004, 32'h0000_5000);
    txn(32'h0000_1000, 1'b0, 32'h0, rdata, lat);
    check("walk_pde", rdata, 32'h0000_2000);
    txn(32'h0000_2004, 1'b0, 32'h0, rdata, lat);
    check("walk_pte", rdata, 32'h0000_5000);
    check("walk_rd_cnt", rd_cnt, 32'd2);

    // Committed write, then an aborted write to the same word
    pulse_reset();
    txn(32'h0000_0040, 1'b1, 32'hA5A5_A5A5, rdata, lat);
    check("wr_latency", 32'(lat), 32'd4);
    addr     = 32'h0000_0040;
    we       = 1'b1;
    drv_data = 32'h1111_1111;
    drv_en   = 1'b1;
    req      = 1'b1;
    tick();
    tick();
    req    = 1'b0;
    drv_en = 1'b0;
    saw_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ack) saw_ack = 1'b1;
    end
    check("abort_no_ack", {31'd0, saw_ack}, 32'd0);
    check("abort_cnt", abort_cnt, 32'd1);
    check("abort_wr_cnt", wr_cnt, 32'd1);
    txn(32'h0000_0040, 1'b0, 32'h0, rdata, lat);
    check("abort_kept_data", rdata, 32'hA5A5_A5A5);

    // Address range boundaries
    pulse_reset();
    txn(32'h0001_0000, 1'b0, 32'h0, rdata, lat);
    check("oor_rd_data", rdata, 32'hDEAD_BEEF);
    check("oor_err_cnt", err_cnt, 32'd1);
    check("oor_rd_cnt", rd_cnt, 32'd1);
    backdoor(32'h0000_0000, 32'h1234_5678);
    backdoor(32'h0001_0000, 32'h7777_7777);
    txn(32'h0000_0000, 1'b0, 32'h0, rdata, lat);
    check("oor_load_ignored", rdata, 32'h1234_5678);
    backdoor(32'h0000_3FFC, 32'hCAFE_F00D);
    txn(32'h0000_3FFC, 1'b0, 32'h0, rdata, lat);
    check("last_word", rdata, 32'hCAFE_F00D);
    txn(32'h0001_0000, 1'b1, 32'h9999_9999, rdata, lat);
    check("oor_wr_err_cnt", err_cnt, 32'd2);
    txn(32'h0000_0000, 1'b0, 32'h0, rdata, lat);
    check("oor_wr_discarded", rdata, 32'h1234_5678);

    // Asynchronous reset while acknowledging a write
    pulse_reset();
    addr     = 32'h0000_0080;
    we       = 1'b1;
    drv_data = 32'h0BAD_F00D;
    drv_en   = 1'b1;
    req      = 1'b1;
    lat      = 0;
    while (!ack && lat < 40) begin
      tick();
      lat++;
    end
    check("ack_before_rst", {31'd0, ack}, 32'd1);
    check("wr_cnt_before_rst", wr_cnt, 32'd1);
    #2 rst_n = 1'b0;
    req    = 1'b0;
    drv_en = 1'b0;
    #1;
    check("async_ack_drop", {31'd0, ack}, 32'd0);
    check("async_wr_cnt", wr_cnt, 32'd0);
    check("async_bus", bus, 32'hFFFF_FFFF);
    tick();
    rst_n = 1'b1;
    tick();
    txn(32'h0000_0080, 1'b0, 32'h0, rdata, lat);
    check("rst_kept_word", rdata, 32'h0BAD_F00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
